// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_pkg                                                      |
// | Purpose  : Shared constants and helpers for the seven-segment scanner:   |
// |            hex-to-segment table (a..g, active-low), blank pattern,       |
// |            slot sub-divider and digit-index width helpers.               |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package seg7_pkg;

   // All segments and the decimal point off (active-low outputs).
   localparam logic [7:0] C_SEG_BLANK = 8'hFF;

   // Segment patterns a..g, active-low, indexed by the hex nibble.
   localparam logic [15:0][6:0] C_HEX_SEG = {
      7'b0111000,   // F
      7'b0110000,   // E
      7'b1000010,   // d
      7'b0110001,   // C
      7'b1100000,   // b
      7'b0001000,   // A
      7'b0000100,   // 9
      7'b0000000,   // 8
      7'b0001111,   // 7
      7'b0100000,   // 6
      7'b0100100,   // 5
      7'b1001100,   // 4
      7'b0000110,   // 3
      7'b0010010,   // 2
      7'b1001111,   // 1
      7'b0000001    // 0
   };

   function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
      return C_HEX_SEG[nibble];
   endfunction

   // Clocks per PWM phase step: one slot is split into 16 brightness phases.
   function automatic int sub_div(input int clk_hz, input int scan_hz);
      return (clk_hz / scan_hz) / 16;
   endfunction

   // Width of the digit index; a single-digit display still needs one bit.
   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_rategen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_rategen                                                  |
// | Purpose  : Divides the system clock into PWM sub-ticks and 16-phase      |
// |            digit slots.                                                  |
// | Ports    : clk, rst         - clock, async active-high reset            |
// |            phase_o[3:0]     - current PWM phase within the slot         |
// |            slot_end_o       - high on the last clock of a slot          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_rategen
   import seg7_pkg::*;
#(
   parameter int CLK_HZ  = 16_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] phase_o,
   output logic       slot_end_o
);

   localparam int SUB   = sub_div(CLK_HZ, SCAN_HZ);
   localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

   generate
      if (SUB < 1) begin : g_sub_check
         $error("seg7_rategen: CLK_HZ/SCAN_HZ must be at least 16");
      end
   endgenerate

   logic [SUB_W-1:0] sub_q, sub_d;
   logic [3:0]       phase_q, phase_d;
   logic             w_sub_tick;

   assign w_sub_tick = (sub_q == SUB_W'(SUB - 1));
   assign phase_o    = phase_q;
   assign slot_end_o = w_sub_tick && (phase_q == 4'hF);

   always_comb begin
      sub_d   = w_sub_tick ? '0 : sub_q + 1'b1;
      phase_d = w_sub_tick ? phase_q + 4'h1 : phase_q;   // wraps 15 -> 0
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_q   <= '0;
         phase_q <= 4'h0;
      end else begin
         sub_q   <= sub_d;
         phase_q <= phase_d;
      end
   end

endmodule : seg7_rategen
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_mux                                                 |
// | Purpose  : Time-multiplexed common-anode seven-segment driver with       |
// |            double-buffered load, per-digit dp/blank, 16-level PWM        |
// |            brightness, ghosting guard cycle and frame-done pulse.        |
// | Ports    : clk, rst          - clock, async active-high reset           |
// |            load              - capture din/dp/blank into pending buffer |
// |            din[4*DIGITS-1:0] - nibble per digit, digit 0 rightmost      |
// |            dp, blank         - per-digit decimal point / force dark     |
// |            bright[3:0]       - PWM level, 0 = 1/16 duty, 15 = full      |
// |            AN, SEG           - active-low anodes / segments {a..g,dp}   |
// |            frame             - pulse when the last digit's slot ends    |
// | Config   : SEG7_LZB_EN       - define to enable leading-zero blanking   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int CLK_HZ  = 16_000_000,
   parameter int SCAN_HZ = 1000,
   parameter int DIGITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     AN,
   output logic [7:0]            SEG,
   output logic                  frame
);

   localparam int              IDX_W      = idx_width(DIGITS);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

   generate
      if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
         $error("seg7_scan_mux: DIGITS must be in 1..8");
      end
   endgenerate

   logic [3:0] w_phase;
   logic       w_slot_end;
   logic       w_frame_end;

   seg7_rategen #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_rategen (
      .clk        (clk),
      .rst        (rst),
      .phase_o    (w_phase),
      .slot_end_o (w_slot_end)
   );

   logic [4*DIGITS-1:0] pend_din_q, pend_din_d, disp_din_q, disp_din_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          bright_q, bright_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_q, frame_d;

   assign w_frame_end = w_slot_end && (idx_q == C_LAST_IDX);

   // Buffers, digit index and per-slot brightness.
   always_comb begin
      pend_din_d   = pend_din_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      disp_din_d   = disp_din_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
      idx_d        = idx_q;
      bright_d     = bright_q;
      if (load) begin
         pend_din_d   = din;
         pend_dp_d    = dp;
         pend_blank_d = blank;
      end
      // Copying the next-state pending buffer makes a load in the boundary
      // cycle land directly in the display buffer.
      if (w_frame_end) begin
         disp_din_d   = pend_din_d;
         disp_dp_d    = pend_dp_d;
         disp_blank_d = pend_blank_d;
      end
      if (w_slot_end) begin
         idx_d    = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
         bright_d = bright;
      end
   end

`ifdef SEG7_LZB_EN
   // A digit is auto-blanked while it and every higher digit is zero with
   // no decimal point; digit 0 always stays visible.
   function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] nib_v,
                                                  input logic [DIGITS-1:0]   dp_v);
      logic [DIGITS-1:0] m;
      logic              run;
      m   = '0;
      run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run  = run & (nib_v[4*i +: 4] == 4'h0) & ~dp_v[i];
         m[i] = run;
      end
      return m;
   endfunction
`endif

   logic [DIGITS-1:0] w_cur_mask, w_nxt_mask;
`ifdef SEG7_LZB_EN
   assign w_cur_mask = disp_blank_q | lzb_mask(disp_din_q, disp_dp_q);
   assign w_nxt_mask = disp_blank_d | lzb_mask(disp_din_d, disp_dp_d);
`else
   assign w_cur_mask = disp_blank_q;
   assign w_nxt_mask = disp_blank_d;
`endif

   // Current digit drives normal cycles; the upcoming digit presets SEG
   // during the guard cycle so segments are settled before its anode drops.
   logic [3:0] w_cur_nib, w_nxt_nib;
   logic       w_cur_dp, w_nxt_dp, w_cur_dark, w_nxt_dark;

   assign w_cur_nib  = disp_din_q[{idx_q, 2'b00} +: 4];
   assign w_cur_dp   = disp_dp_q[idx_q];
   assign w_cur_dark = w_cur_mask[idx_q];
   assign w_nxt_nib  = disp_din_d[{idx_d, 2'b00} +: 4];
   assign w_nxt_dp   = disp_dp_d[idx_d];
   assign w_nxt_dark = w_nxt_mask[idx_d];

   always_comb begin
      an_d    = '1;
      seg_d   = C_SEG_BLANK;
      frame_d = w_frame_end;
      if (w_slot_end) begin
         if (!w_nxt_dark) begin
            seg_d = {hex2seg(w_nxt_nib), ~w_nxt_dp};
         end
      end else if (!w_cur_dark && (w_phase <= bright_q)) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         seg_d = {hex2seg(w_cur_nib), ~w_cur_dp};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_din_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '1;
         disp_din_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '1;
         idx_q        <= '0;
         bright_q     <= 4'h0;
         an_q         <= '1;
         seg_q        <= C_SEG_BLANK;
         frame_q      <= 1'b0;
      end else begin
         pend_din_q   <= pend_din_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         disp_din_q   <= disp_din_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         idx_q        <= idx_d;
         bright_q     <= bright_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_q      <= frame_d;
      end
   end

   assign AN    = an_q;
   assign SEG   = seg_q;
   assign frame = frame_q;

endmodule : seg7_scan_mux
`default_nettype wire
